chacha_ctrl: RTL

//   Initiator/sequencer for the four column quarter-round units. Accepts 48
//   key/counter/nonce bytes from a host stream and writes them into the state

---
 rtl/chacha_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/chacha_ctrl.sv
// Sequencer for the ChaCha quarter-round array: clears the array, loads key/counter/nonce
// bytes from the host, steps ROUNDS rounds of calc cycles, then streams the raw state out.
module chacha_ctrl #(
    parameter int ROUNDS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       blk_clear,
    output logic       blk_write,
    output logic       blk_calc,
    output logic [1:0] blk_step,
    output logic       blk_diag,
    output logic [5:0] blk_addr,
    output logic [7:0] blk_wdata,
    input  logic [7:0] blk_rdata
);

    // Handshakes: a byte moves on a cycle where valid and ready are both high at the
    // rising clock edge; valid/ready never wait on each other combinationally here.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [4:0] LAST_RND   = 5'(ROUNDS - 1);
    localparam logic [5:0] FIRST_LOAD = 6'd16;
    localparam logic [5:0] LAST_BYTE  = 6'd63;

    state_t     state_q, state_d;
    logic [5:0] byte_cnt_q, byte_cnt_d;
    logic [4:0] rnd_cnt_q, rnd_cnt_d;
    logic [1:0] step_cnt_q, step_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= 6'd0;
            rnd_cnt_q  <= 5'd0;
            step_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            rnd_cnt_q  <= rnd_cnt_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        rnd_cnt_d  = rnd_cnt_q;
        step_cnt_d = step_cnt_q;
        busy       = 1'b0;
        done       = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'd0;
        blk_clear  = 1'b0;
        blk_write  = 1'b0;
        blk_calc   = 1'b0;
        blk_step   = 2'd0;
        blk_diag   = 1'b0;
        blk_addr   = 6'd0;
        blk_wdata  = 8'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end

            S_CLEAR: begin
                busy       = 1'b1;
                blk_clear  = 1'b1;
                byte_cnt_d = FIRST_LOAD;
                state_d    = S_LOAD;
            end

            // Host bytes go straight through to the array; row 0 keeps its reset constants.
            S_LOAD: begin
                busy      = 1'b1;
                in_ready  = 1'b1;
                blk_write = in_valid;
                blk_addr  = byte_cnt_q;
                blk_wdata = in_data;
                if (in_valid) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = 6'd0;
                        state_d    = S_RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end

            // Even rounds use column routing, odd rounds diagonal routing.
            S_RUN: begin
                busy     = 1'b1;
                blk_calc = 1'b1;
                blk_step = step_cnt_q;
                blk_diag = rnd_cnt_q[0];
                if (step_cnt_q == 2'd3) begin
                    step_cnt_d = 2'd0;
                    if (rnd_cnt_q == LAST_RND) begin
                        rnd_cnt_d = 5'd0;
                        state_d   = S_OUT;
                    end else begin
                        rnd_cnt_d = rnd_cnt_q + 5'd1;
                    end
                end else begin
                    step_cnt_d = step_cnt_q + 2'd1;
                end
            end

            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                blk_addr  = byte_cnt_q;
                out_data  = blk_rdata;
                if (out_ready) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        done       = 1'b1;
                        byte_cnt_d = 6'd0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
